// File: rtl/toast_fetch_unit_pkg.sv
// ToastCore fetch definitions: fetch FSM states, NOP, reset PC, queue entry.
// Shared by toast_fetch_unit and toast_fetch_queue.
package toast_fetch_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/toast_fetch_queue.sv
// 2-entry {pc, instruction} FIFO; slot 0 is always the head.
// Ports: Clk, Reset, push/pop/flush, push_entry in; head, head_valid, count out.
module toast_fetch_queue
  import toast_fetch_unit_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t s0_q, s1_q, s0_n, s1_n;
  logic         v0_q, v1_q, v0_n, v1_n;

  always_comb begin
    s0_n = s0_q;
    s1_n = s1_q;
    v0_n = v0_q;
    v1_n = v1_q;
    if (pop && v0_q) begin
      s0_n = s1_q;
      v0_n = v1_q;
      v1_n = 1'b0;
    end
    if (push) begin
      if (!v0_n) begin
        s0_n = push_entry;
        v0_n = 1'b1;
      end else if (!v1_n) begin
        s1_n = push_entry;
        v1_n = 1'b1;
      end
    end
    if (flush) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s0_q <= '{pc: 32'h0, instr: NOP};
      s1_q <= '{pc: 32'h0, instr: NOP};
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      s0_q <= s0_n;
      s1_q <= s1_n;
      v0_q <= v0_n;
      v1_q <= v1_n;
    end
  end

  assign head       = s0_q;
  assign head_valid = v0_q;
  assign count      = {1'b0, v0_q} + {1'b0, v1_q};

endmodule

// File: rtl/toast_fetch_unit.sv
// ToastCore IF stage: PC, imem issue, 2-entry fetch queue, EX redirect flush.
// Optional TOAST_FETCH_MISALIGN_EN adds HALT on misaligned target + IF_Misaligned.
module toast_fetch_unit
  import toast_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_PC_Branch,
  input  logic [31:0] EX_PC_Target,
  input  logic        ID_Stall,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic        IF_Valid
`ifdef TOAST_FETCH_MISALIGN_EN
  ,
  output logic        IF_Misaligned
`endif
);

  localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

  fetch_state_t state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  inflight_pc_q;
  logic         inflight_q;
  logic [31:0]  target;
  logic         run, redirect, bad_target;
  logic         pop, issue, rd_en;
  logic [1:0]   count;
  logic [2:0]   occ;
  fetch_entry_t head, push_entry;
  logic         head_valid;

`ifdef TOAST_FETCH_MISALIGN_EN
  assign target     = EX_PC_Target;
  assign bad_target = redirect & (target[1:0] != 2'b00);
`else
  assign target     = EX_PC_Target & 32'hFFFF_FFFC;
  assign bad_target = 1'b0;
`endif

  assign run      = (state_q == RUN);
  assign redirect = EX_PC_Branch & run;
  assign pop      = head_valid & ~ID_Stall;
  assign occ      = {1'b0, count} + {2'b00, inflight_q};

  // Room exists now, or the head leaves this cycle.
  assign issue = run & ((occ < DEPTH) |
                        ((occ == DEPTH) & pop));

  assign rd_en = ~Reset &
                 (redirect ? ~bad_target : issue);

  assign imem_rd_en = rd_en;
  assign imem_addr  = !rd_en   ? 32'h0 :
                      redirect ? target : fetch_pc_q;

  assign push_entry = '{pc: inflight_pc_q,
                        instr: imem_rd_data};

  // Flush beats push, so the word of a read
  // issued before a redirect never lands.
  toast_fetch_queue u_queue (
    .Clk        (Clk),
    .Reset      (Reset),
    .push       (inflight_q),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en)
        inflight_pc_q <= imem_addr;
      unique case (1'b1)
        redirect & ~bad_target:
          fetch_pc_q <= target + 32'd4;
        ~redirect & issue:
          fetch_pc_q <= fetch_pc_q + 32'd4;
        default: ;
      endcase
`ifdef TOAST_FETCH_MISALIGN_EN
      if (bad_target)
        state_q <= HALT;
`endif
    end
  end

`ifdef TOAST_FETCH_MISALIGN_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      IF_Misaligned <= 1'b0;
    else if (bad_target)
      IF_Misaligned <= 1'b1;
  end
`endif

  assign IF_Valid       = head_valid;
  assign IF_PC          = head.pc;
  assign IF_Instruction = head_valid ? head.instr : NOP;

endmodule

// File: tb/tb_toast_fetch_unit.sv
// Directed bench for toast_fetch_unit with a 1-cycle synchronous imem model.
// Covers reset, streaming, stalls, redirects, wrap and alignment handling.
module tb_toast_fetch_unit;
  import toast_fetch_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        EX_PC_Branch = 1'b0;
  logic [31:0] EX_PC_Target = 32'h0;
  logic        ID_Stall = 1'b0;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data = 32'h0;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic        IF_Valid;
`ifdef TOAST_FETCH_MISALIGN_EN
  logic        IF_Misaligned;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  toast_fetch_unit dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .EX_PC_Branch   (EX_PC_Branch),
    .EX_PC_Target   (EX_PC_Target),
    .ID_Stall       (ID_Stall),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .IF_Valid       (IF_Valid)
`ifdef TOAST_FETCH_MISALIGN_EN
    ,
    .IF_Misaligned  (IF_Misaligned)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h0BAD_0000;
  endfunction

  always @(posedge Clk)
    if (imem_rd_en)
      imem_rd_data <= instr_of(imem_addr);

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1ns into cycle 0.
  task automatic do_reset;
    Reset = 1'b1;
    EX_PC_Branch = 1'b0;
    EX_PC_Target = 32'h0;
    ID_Stall = 1'b0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    EX_PC_Branch = 1'b1;
    EX_PC_Target = 32'h80;
    tick;
    tick;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_en got %0b want 0", imem_rd_en);
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_addr got %h want 0", imem_addr);
    end
    n_cmp++;
    if (IF_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %0b want 0", IF_Valid);
    end
    n_cmp++;
    if (IF_Instruction !== NOP) begin
      n_fail++;
      $display("FAIL rst_instr got %h want %h", IF_Instruction, NOP);
    end
    n_cmp++;
    if (IF_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_pc got %h want 0", IF_PC);
    end
    EX_PC_Branch = 1'b0;
    tick;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_first_issue got %0b/%h want 1/0",
               imem_rd_en, imem_addr);
    end
    tick;
    n_cmp++;
    if (IF_Valid !== 1'b0 || imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL rst_cycle1 got v%0b/%h want v0/4",
               IF_Valid, imem_addr);
    end
  endtask

  task automatic test_steady;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (IF_Valid !== (c >= 2)) begin
        n_fail++;
        $display("FAIL steady_valid c%0d got %0b", c, IF_Valid);
      end
      if (c >= 2) begin
        n_cmp++;
        if (IF_PC !== 32'(4 * (c - 2)) ||
            IF_Instruction !== instr_of(32'(4 * (c - 2)))) begin
          n_fail++;
          $display("FAIL steady_head c%0d got %h/%h want pc %h",
                   c, IF_PC, IF_Instruction, 4 * (c - 2));
        end
      end
      n_cmp++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 32'(4 * c)) begin
        n_fail++;
        $display("FAIL steady_issue c%0d got %0b/%h want 1/%h",
                 c, imem_rd_en, imem_addr, 4 * c);
      end
      tick;
    end
  endtask

  task automatic test_stall;
    logic [31:0] ep[12];
    logic        ee[12];
    logic [31:0] ea[12];
    ep = '{0, 0, 0, 4, 4, 4, 4, 4, 4, 8, 12, 16};
    ee = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    ea = '{0, 4, 8, 0, 0, 0, 0, 0, 12, 16, 20, 24};
    do_reset;
    for (int c = 0; c < 12; c++) begin
      ID_Stall = (c >= 3 && c <= 7);
      #1;
      n_cmp++;
      if (IF_Valid !== (c >= 2)) begin
        n_fail++;
        $display("FAIL stall_valid c%0d got %0b", c, IF_Valid);
      end
      if (c >= 2) begin
        n_cmp++;
        if (IF_PC !== ep[c] || IF_Instruction !== instr_of(ep[c])) begin
          n_fail++;
          $display("FAIL stall_head c%0d got %h want %h",
                   c, IF_PC, ep[c]);
        end
      end
      n_cmp++;
      if (imem_rd_en !== ee[c] ||
          (ee[c] && imem_addr !== ea[c])) begin
        n_fail++;
        $display("FAIL stall_issue c%0d got %0b/%h want %0b/%h",
                 c, imem_rd_en, imem_addr, ee[c], ea[c]);
      end
      tick;
    end
    ID_Stall = 1'b0;
  endtask

  task automatic test_redirect;
    logic        ev[11];
    logic [31:0] ep[11];
    logic [31:0] ea[11];
    ev = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    ep = '{0, 0, 0, 4, 8, 12, 16, 0, 'h24, 'h28, 'h2C};
    ea = '{0, 4, 8, 12, 16, 20, 'h24, 'h28, 'h2C, 'h30, 'h34};
    do_reset;
    for (int c = 0; c < 11; c++) begin
      EX_PC_Branch = (c == 6);
      EX_PC_Target = 32'h24;
      #1;
      n_cmp++;
      if (IF_Valid !== ev[c]) begin
        n_fail++;
        $display("FAIL redir_valid c%0d got %0b want %0b",
                 c, IF_Valid, ev[c]);
      end
      n_cmp++;
      if (ev[c] ? (IF_PC !== ep[c] ||
                   IF_Instruction !== instr_of(ep[c]))
                : (IF_Instruction !== NOP)) begin
        n_fail++;
        $display("FAIL redir_head c%0d got %h/%h want pc %h",
                 c, IF_PC, IF_Instruction, ep[c]);
      end
      n_cmp++;
      if (imem_rd_en !== 1'b1 || imem_addr !== ea[c]) begin
        n_fail++;
        $display("FAIL redir_issue c%0d got %0b/%h want 1/%h",
                 c, imem_rd_en, imem_addr, ea[c]);
      end
      tick;
    end
    EX_PC_Branch = 1'b0;
  endtask

  task automatic test_redirect_stall;
    logic [31:0] ep[10];
    logic        ee[10];
    logic [31:0] ea[10];
    ep = '{0, 0, 0, 4, 4, 4, 0, 'h100, 'h104, 'h108};
    ee = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    ea = '{0, 4, 8, 0, 0, 'h100, 'h104, 'h108, 'h10C, 'h110};
    do_reset;
    for (int c = 0; c < 10; c++) begin
      ID_Stall = (c >= 3 && c <= 5);
      EX_PC_Branch = (c == 5);
      EX_PC_Target = 32'h100;
      #1;
      n_cmp++;
      if (IF_Valid !== (c >= 2 && c != 6)) begin
        n_fail++;
        $display("FAIL rstall_valid c%0d got %0b", c, IF_Valid);
      end
      if (c >= 2 && c != 6) begin
        n_cmp++;
        if (IF_PC !== ep[c] || IF_Instruction !== instr_of(ep[c])) begin
          n_fail++;
          $display("FAIL rstall_head c%0d got %h want %h",
                   c, IF_PC, ep[c]);
        end
      end
      n_cmp++;
      if (imem_rd_en !== ee[c] ||
          (ee[c] && imem_addr !== ea[c])) begin
        n_fail++;
        $display("FAIL rstall_issue c%0d got %0b/%h want %0b/%h",
                 c, imem_rd_en, imem_addr, ee[c], ea[c]);
      end
      tick;
    end
    ID_Stall = 1'b0;
    EX_PC_Branch = 1'b0;
  endtask

  task automatic test_wrap;
    logic [31:0] ep[8];
    logic [31:0] ea[8];
    ep = '{0, 0, 0, 4, 0, 'hFFFF_FFFC, 0, 4};
    ea = '{0, 4, 8, 'hFFFF_FFFC, 0, 4, 8, 12};
    do_reset;
    for (int c = 0; c < 8; c++) begin
      EX_PC_Branch = (c == 3);
      EX_PC_Target = 32'hFFFF_FFFC;
      #1;
      n_cmp++;
      if (IF_Valid !== (c >= 2 && c != 4)) begin
        n_fail++;
        $display("FAIL wrap_valid c%0d got %0b", c, IF_Valid);
      end
      if (c >= 2 && c != 4) begin
        n_cmp++;
        if (IF_PC !== ep[c] || IF_Instruction !== instr_of(ep[c])) begin
          n_fail++;
          $display("FAIL wrap_head c%0d got %h want %h",
                   c, IF_PC, ep[c]);
        end
      end
      n_cmp++;
      if (imem_rd_en !== 1'b1 || imem_addr !== ea[c]) begin
        n_fail++;
        $display("FAIL wrap_issue c%0d got %0b/%h want 1/%h",
                 c, imem_rd_en, imem_addr, ea[c]);
      end
      tick;
    end
    EX_PC_Branch = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic        ev[9];
    logic [31:0] ep[9];
    logic [31:0] ea[9];
    ev = '{0, 0, 1, 1, 0, 0, 1, 1, 1};
    ep = '{0, 0, 0, 4, 0, 0, 'h84, 'h88, 'h8C};
    ea = '{0, 4, 8, 'h40, 'h84, 'h88, 'h8C, 'h90, 'h94};
    do_reset;
    for (int c = 0; c < 9; c++) begin
      EX_PC_Branch = (c == 3 || c == 4);
      EX_PC_Target = (c == 3) ? 32'h40 : 32'h84;
      #1;
      n_cmp++;
      if (IF_Valid !== ev[c]) begin
        n_fail++;
        $display("FAIL b2b_valid c%0d got %0b want %0b",
                 c, IF_Valid, ev[c]);
      end
      if (ev[c]) begin
        n_cmp++;
        if (IF_PC !== ep[c] || IF_Instruction !== instr_of(ep[c])) begin
          n_fail++;
          $display("FAIL b2b_head c%0d got %h want %h",
                   c, IF_PC, ep[c]);
        end
      end
      n_cmp++;
      if (imem_rd_en !== 1'b1 || imem_addr !== ea[c]) begin
        n_fail++;
        $display("FAIL b2b_issue c%0d got %0b/%h want 1/%h",
                 c, imem_rd_en, imem_addr, ea[c]);
      end
      tick;
    end
    EX_PC_Branch = 1'b0;
  endtask

`ifndef TOAST_FETCH_MISALIGN_EN
  task automatic test_align_force;
    do_reset;
    tick;
    tick;
    tick;
    EX_PC_Branch = 1'b1;
    EX_PC_Target = 32'h26;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 32'h24) begin
      n_fail++;
      $display("FAIL align_issue got %0b/%h want 1/24",
               imem_rd_en, imem_addr);
    end
    tick;
    EX_PC_Branch = 1'b0;
    tick;
    #1;
    n_cmp++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h24 ||
        IF_Instruction !== instr_of(32'h24)) begin
      n_fail++;
      $display("FAIL align_head got v%0b %h want v1 24",
               IF_Valid, IF_PC);
    end
    tick;
    #1;
    n_cmp++;
    if (IF_PC !== 32'h28) begin
      n_fail++;
      $display("FAIL align_next got %h want 28", IF_PC);
    end
  endtask
`else
  task automatic test_misalign;
    do_reset;
    tick;
    tick;
    tick;
    EX_PC_Branch = 1'b1;
    EX_PC_Target = 32'h22;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_issue got %0b want 0", imem_rd_en);
    end
    tick;
    EX_PC_Branch = 1'b0;
    #1;
    n_cmp++;
    if (IF_Misaligned !== 1'b1 || IF_Valid !== 1'b0 ||
        imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_halt got m%0b v%0b e%0b want 1/0/0",
               IF_Misaligned, IF_Valid, imem_rd_en);
    end
    tick;
    EX_PC_Branch = 1'b1;
    EX_PC_Target = 32'h40;
    #1;
    n_cmp++;
    if (imem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_ignore got %0b want 0", imem_rd_en);
    end
    tick;
    EX_PC_Branch = 1'b0;
    tick;
    #1;
    n_cmp++;
    if (IF_Valid !== 1'b0 || IF_Misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_stay got v%0b m%0b want 0/1",
               IF_Valid, IF_Misaligned);
    end
    do_reset;
    #1;
    n_cmp++;
    if (IF_Misaligned !== 1'b0 || imem_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_reset got m%0b e%0b want 0/1",
               IF_Misaligned, imem_rd_en);
    end
    tick;
    tick;
    #1;
    n_cmp++;
    if (IF_Valid !== 1'b1 || IF_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_restart got v%0b %h want v1 0",
               IF_Valid, IF_PC);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_steady;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_back_to_back;
`ifndef TOAST_FETCH_MISALIGN_EN
    test_align_force;
`else
    test_misalign;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
